// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared types and constants for the instruction/data memory
//               arbiter: FSM state encoding, bus owner encoding and the
//               width of the DMCtrl size/sign code.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Width of the DMCtrl size/sign code carried with data accesses.
  localparam int DMCTRL_W = 3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_FE = 2'd1,
    BUSY_ME = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  // Which requester currently owns the memory port.
  typedef enum logic {
    OWN_FE = 1'b0,
    OWN_ME = 1'b1
  } arb_owner_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/imem_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : imem_dmem_arbiter_if
// Description : Bundles the fetch-stage, memory-stage and unified-memory
//               handshake signals around the arbiter.
//               slave  : arbiter view (serves the pipeline, drives memory)
//               master : environment view (pipeline stages + memory)
// Ports       : fe_*   fetch request/response/stall, flush
//               me_*   data request/response/stall
//               mem_*  unified memory request/ack bus
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import arb_pkg::*;

  // Fetch stage
  logic                fe_req;
  logic [ADDR_W-1:0]   fe_addr;
  logic [DATA_W-1:0]   fe_rdata;
  logic                fe_valid;
  logic                fe_stall;
  logic                flush;

  // Memory stage
  logic                me_req;
  logic                me_we;
  logic [ADDR_W-1:0]   me_addr;
  logic [DATA_W-1:0]   me_wdata;
  logic [DMCTRL_W-1:0] me_ctrl;
  logic [DATA_W-1:0]   me_rdata;
  logic                me_valid;
  logic                me_stall;

  // Unified memory
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DMCTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  modport slave (
    input  fe_req, fe_addr, flush,
    input  me_req, me_we, me_addr, me_wdata, me_ctrl,
    input  mem_rdata, mem_ack,
    output fe_rdata, fe_valid, fe_stall,
    output me_rdata, me_valid, me_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl
  );

  modport master (
    output fe_req, fe_addr, flush,
    output me_req, me_we, me_addr, me_wdata, me_ctrl,
    output mem_rdata, mem_ack,
    input  fe_rdata, fe_valid, fe_stall,
    input  me_rdata, me_valid, me_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl
  );

endinterface : imem_dmem_arbiter_if
`default_nettype wire

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_ctr
// Description : Counts data-port grants issued while a fetch is waiting.
//               Once STARVE_MAX such grants have been issued, force_fe_o
//               asks the arbiter to serve the fetch at the next arbitration.
// Ports       : clk, rst      clock and synchronous active-high reset
//               me_grant_i    data port granted this cycle
//               fe_grant_i    fetch port granted this cycle
//               fe_req_i      fetch currently requesting
//               force_fe_o    next arbitration must go to the fetch port
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic me_grant_i,
  input  logic fe_grant_i,
  input  logic fe_req_i,
  output logic force_fe_o
);

  localparam int               CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fe_grant_i || !fe_req_i) begin
      cnt_d = '0;
    end else if (me_grant_i && (cnt_q != C_MAX)) begin
      // Saturates so the force stays asserted until the fetch is served.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fe_o = (cnt_q == C_MAX);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter
// Description : Shares one single-ported unified memory between the fetch
//               stage and the memory stage. The data port has priority;
//               each access is sequenced IDLE -> BUSY_x -> RESP -> IDLE.
//               A flush during a fetch lets the bus cycle finish but
//               suppresses its response.
//               Optional: define ARB_STARVE_EN to bound fetch starvation
//               to STARVE_MAX consecutive data grants.
// Ports       : clk  system clock (rising edge)
//               rst  synchronous active-high reset
//               bus  imem_dmem_arbiter_if.slave (fe_*, me_*, mem_*, flush)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_dmem_arbiter_if.slave  bus
);

  arb_state_e          state_q,     state_d;
  logic                discard_q,   discard_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DMCTRL_W-1:0] mem_ctrl_q,  mem_ctrl_d;
  logic [DATA_W-1:0]   fe_rdata_q,  fe_rdata_d;
  logic [DATA_W-1:0]   me_rdata_q,  me_rdata_d;
  logic                fe_valid_q,  fe_valid_d;
  logic                me_valid_q,  me_valid_d;

  logic w_fe_ok;
  logic w_force_fe;
  logic w_grant_fe;
  logic w_grant_me;
  logic w_kill;

  // A fetch is never granted in the same cycle as a redirect: its PC is stale.
  assign w_fe_ok    = bus.fe_req & ~bus.flush;
  assign w_grant_me = (state_q == IDLE) & bus.me_req & ~(w_force_fe & w_fe_ok);
  assign w_grant_fe = (state_q == IDLE) & w_fe_ok & (~bus.me_req | w_force_fe);

  // Covers a flush arriving in the very cycle the ack returns.
  assign w_kill     = discard_q | bus.flush;

`ifdef ARB_STARVE_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .me_grant_i (w_grant_me),
    .fe_grant_i (w_grant_fe),
    .fe_req_i   (bus.fe_req),
    .force_fe_o (w_force_fe)
  );
`else
  assign w_force_fe = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ctrl_d  = mem_ctrl_q;
    fe_rdata_d  = fe_rdata_q;
    me_rdata_d  = me_rdata_q;
    fe_valid_d  = 1'b0;
    me_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (w_grant_me) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.me_we;
          mem_addr_d  = bus.me_addr;
          mem_wdata_d = bus.me_wdata;
          mem_ctrl_d  = bus.me_ctrl;
          state_d     = BUSY_ME;
        end else if (w_grant_fe) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.fe_addr;
          mem_wdata_d = '0;
          mem_ctrl_d  = '0;
          state_d     = BUSY_FE;
        end
      end

      BUSY_FE: begin
        discard_d = w_kill;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (!w_kill) begin
            fe_rdata_d = bus.mem_rdata;
            fe_valid_d = 1'b1;
          end
        end
      end

      BUSY_ME: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          me_rdata_d = bus.mem_rdata;
          me_valid_d = 1'b1;
          state_d    = RESP;
        end
      end

      RESP: begin
        // Response cycle: no arbitration, so a requester still holding
        // its req while it sees valid is not granted a second time.
        discard_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= '0;
      fe_rdata_q  <= '0;
      me_rdata_q  <= '0;
      fe_valid_q  <= 1'b0;
      me_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ctrl_q  <= mem_ctrl_d;
      fe_rdata_q  <= fe_rdata_d;
      me_rdata_q  <= me_rdata_d;
      fe_valid_q  <= fe_valid_d;
      me_valid_q  <= me_valid_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.fe_rdata  = fe_rdata_q;
  assign bus.me_rdata  = me_rdata_q;
  assign bus.fe_valid  = fe_valid_q;
  assign bus.me_valid  = me_valid_q;

  // While a discarded fetch is still on the bus the redirected PC must wait.
  assign bus.fe_stall  = (bus.fe_req & ~fe_valid_q) | ((state_q == BUSY_FE) & discard_q);
  assign bus.me_stall  = bus.me_req & ~me_valid_q;

endmodule : imem_dmem_arbiter
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_arbiter
// Description : Self-checking bench for imem_dmem_arbiter. A memory model
//               answers mem_req after a programmable delay; expected grants
//               and responses are queued when requests are driven and
//               compared when the arbiter produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    bit          full;
  } grant_t;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ack_delay;
  bit   auto_ack;

  grant_t grant_q[$];
  logic [31:0] fe_q[$];
  resp_t  me_q[$];
  logic [31:0] memory [logic [31:0]];

  imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return memory.exists(a) ? memory[a] : ~a;
  endfunction

  // Memory model: ack arrives ack_delay cycles after mem_req first rises.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        if (rst || !bus.mem_req) begin
          bus.mem_ack = 1'b0;
          cnt = 0;
        end else if (cnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = ref_rd(bus.mem_addr);
          if (bus.mem_we) memory[bus.mem_addr] = bus.mem_wdata;
          cnt++;
        end else begin
          bus.mem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  // Scoreboard: grant contents, bus stability and response data.
  initial begin
    bit          prev_req;
    grant_t      g;
    resp_t       r;
    logic [31:0] e;
    logic [68:0] held;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (bus.mem_req && !prev_req) begin
          checks++;
          if (grant_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected addr=%h we=%b", bus.mem_addr, bus.mem_we);
          end else begin
            g = grant_q.pop_front();
            if (bus.mem_addr !== g.addr || bus.mem_we !== g.we ||
                (g.full && (bus.mem_wdata !== g.wdata || bus.mem_ctrl !== g.ctrl))) begin
              errors++;
              $display("FAIL grant addr=%h we=%b wdata=%h ctrl=%b exp addr=%h we=%b wdata=%h ctrl=%b",
                       bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_ctrl,
                       g.addr, g.we, g.wdata, g.ctrl);
            end
          end
          held = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_ctrl};
        end else if (bus.mem_req) begin
          checks++;
          if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_ctrl} !== held) begin
            errors++;
            $display("FAIL bus_stable got=%h exp=%h",
                     {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_ctrl}, held);
          end
        end
        if (bus.fe_valid === 1'b1) begin
          checks++;
          if (fe_q.size() == 0) begin
            errors++;
            $display("FAIL fe_valid_unexpected rdata=%h", bus.fe_rdata);
          end else begin
            e = fe_q.pop_front();
            if (bus.fe_rdata !== e) begin
              errors++;
              $display("FAIL fe_rdata got=%h exp=%h", bus.fe_rdata, e);
            end
          end
        end
        if (bus.me_valid === 1'b1) begin
          checks++;
          if (me_q.size() == 0) begin
            errors++;
            $display("FAIL me_valid_unexpected rdata=%h", bus.me_rdata);
          end else begin
            r = me_q.pop_front();
            if (r.chk && bus.me_rdata !== r.data) begin
              errors++;
              $display("FAIL me_rdata got=%h exp=%h", bus.me_rdata, r.data);
            end
          end
        end
        prev_req = bus.mem_req;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.fe_req = 0; bus.fe_addr = 0; bus.flush = 0;
    bus.me_req = 0; bus.me_we = 0; bus.me_addr = 0; bus.me_wdata = 0; bus.me_ctrl = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.fe_valid, bus.me_valid, bus.fe_stall, bus.me_stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {bus.mem_req, bus.fe_valid, bus.me_valid, bus.fe_stall, bus.me_stall});
    end
    checks++;
    if (bus.mem_addr !== 0 || bus.mem_wdata !== 0 || bus.mem_ctrl !== 0 || bus.mem_we !== 0 ||
        bus.fe_rdata !== 0 || bus.me_rdata !== 0) begin
      errors++;
      $display("FAIL reset_bus addr=%h wdata=%h ctrl=%b we=%b fe_rdata=%h me_rdata=%h exp all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_ctrl, bus.mem_we, bus.fe_rdata, bus.me_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_basic();
    int pulses, vcyc, stall_hi;
    ack_delay = 1;
    pulses = 0; vcyc = -1; stall_hi = 0;
    @(negedge clk);
    bus.fe_req = 1; bus.fe_addr = 32'h0000_0010;
    grant_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
    fe_q.push_back(32'h0050_0093);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < 2 && bus.fe_stall === 1'b1) stall_hi++;
      if (bus.fe_valid === 1'b1) begin
        pulses++;
        if (vcyc < 0) vcyc = c;
        checks++;
        if (bus.fe_stall !== 1'b0) begin
          errors++;
          $display("FAIL fe_stall_on_valid got=%b exp=0", bus.fe_stall);
        end
        bus.fe_req = 0;
      end
    end
    checks++;
    if (stall_hi != 2) begin
      errors++;
      $display("FAIL fe_stall_early got=%0d cycles exp=2", stall_hi);
    end
    checks++;
    if (pulses != 1 || vcyc != 3) begin
      errors++;
      $display("FAIL fe_latency pulses=%0d cycle=%0d exp pulses=1 cycle=3", pulses, vcyc);
    end
  endtask

  task automatic test_priority();
    int mc, fc;
    ack_delay = 0;
    mc = -1; fc = -1;
    @(negedge clk);
    bus.fe_req = 1; bus.fe_addr = 32'h20;
    bus.me_req = 1; bus.me_we = 0; bus.me_addr = 32'h100; bus.me_wdata = 0; bus.me_ctrl = 3'b010;
    grant_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, ctrl: 3'b010, full: 1'b1});
    grant_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
    me_q.push_back('{chk: 1'b1, data: ref_rd(32'h100)});
    fe_q.push_back(ref_rd(32'h20));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) begin
        checks++;
        if (bus.me_stall !== 1'b1 || bus.fe_stall !== 1'b1) begin
          errors++;
          $display("FAIL both_stall me=%b fe=%b exp 1 1", bus.me_stall, bus.fe_stall);
        end
      end
      if (bus.me_valid === 1'b1 && mc < 0) begin mc = c; bus.me_req = 0; end
      if (bus.fe_valid === 1'b1 && fc < 0) begin fc = c; bus.fe_req = 0; end
    end
    checks++;
    if (mc != 2 || fc != 5) begin
      errors++;
      $display("FAIL priority me_cycle=%0d fe_cycle=%0d exp 2 5", mc, fc);
    end
  endtask

  task automatic test_store();
    int reqc, vc, pulses;
    ack_delay = 4;
    reqc = 0; vc = -1; pulses = 0;
    @(negedge clk);
    bus.me_req = 1; bus.me_we = 1; bus.me_addr = 32'h200;
    bus.me_wdata = 32'hDEAD_BEEF; bus.me_ctrl = 3'b010;
    grant_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF, ctrl: 3'b010, full: 1'b1});
    me_q.push_back('{chk: 1'b0, data: 32'h0});
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.mem_req === 1'b1) reqc++;
      if (bus.me_valid === 1'b1) begin
        pulses++;
        if (vc < 0) vc = c;
        bus.me_req = 0; bus.me_we = 0;
      end
    end
    checks++;
    if (reqc != 5 || vc != 6 || pulses != 1) begin
      errors++;
      $display("FAIL store_timing req_cycles=%0d valid_cycle=%0d pulses=%0d exp 5 6 1",
               reqc, vc, pulses);
    end
  endtask

  task automatic test_flush();
    int stall_hi, gc, vc;
    ack_delay = 3;
    stall_hi = 0; gc = -1; vc = -1;
    @(negedge clk);
    bus.fe_req = 1; bus.fe_addr = 32'h40;
    grant_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        bus.flush = 1; bus.fe_addr = 32'h80;
        grant_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
        fe_q.push_back(ref_rd(32'h80));
      end
      if (c == 3) bus.flush = 0;
      #1;
      if (c <= 4 && bus.fe_stall === 1'b1) stall_hi++;
      if (gc < 0 && bus.mem_req === 1'b1 && bus.mem_addr === 32'h80) gc = c;
      if (bus.fe_valid === 1'b1 && vc < 0) begin vc = c; bus.fe_req = 0; end
    end
    checks++;
    if (stall_hi != 5) begin
      errors++;
      $display("FAIL flush_stall got=%0d cycles exp=5", stall_hi);
    end
    checks++;
    if (gc != 7 || vc != 11) begin
      errors++;
      $display("FAIL flush_regrant req_cycle=%0d valid_cycle=%0d exp 7 11", gc, vc);
    end
  endtask

  task automatic test_reset_midway();
    int bad;
    auto_ack = 0;
    bus.mem_ack = 0;
    bad = 0;
    @(negedge clk);
    bus.me_req = 1; bus.me_we = 0; bus.me_addr = 32'h180; bus.me_ctrl = 3'b010; bus.me_wdata = 0;
    grant_q.push_back('{we: 1'b0, addr: 32'h180, wdata: 32'h0, ctrl: 3'b010, full: 1'b1});
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midway_busy mem_req=%b exp=1", bus.mem_req);
    end
    @(negedge clk);
    rst = 1; bus.me_req = 0;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || dut.state_q !== IDLE || bus.me_valid !== 1'b0) begin
      errors++;
      $display("FAIL midway_reset mem_req=%b state=%0d me_valid=%b exp 0 0 0",
               bus.mem_req, dut.state_q, bus.me_valid);
    end
    for (int c = 4; c < 9; c++) begin
      @(negedge clk);
      if (c == 4) begin bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678; end
      if (c == 5) bus.mem_ack = 0;
      #1;
      if (bus.me_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.me_rdata !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL midway_ack_ignored bad_cycles=%0d state=%0d exp 0 0", bad, dut.state_q);
    end
    auto_ack = 1;
  endtask

  task automatic test_starve();
    int n_before, k, fe_pos, c;
    ack_delay = 0;
`ifdef ARB_STARVE_EN
    n_before = 4;
`else
    n_before = 6;
`endif
    k = 0; fe_pos = -1;
    for (int i = 0; i < 6; i++) begin
      if (i == n_before)
        grant_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
      grant_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0, ctrl: 3'b010, full: 1'b1});
      me_q.push_back('{chk: 1'b1, data: ref_rd(32'h300 + 32'(4 * i))});
    end
    if (n_before == 6)
      grant_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, ctrl: 3'b0, full: 1'b0});
    fe_q.push_back(ref_rd(32'h400));
    @(negedge clk);
    bus.fe_req = 1; bus.fe_addr = 32'h400;
    bus.me_req = 1; bus.me_we = 0; bus.me_addr = 32'h300; bus.me_wdata = 0; bus.me_ctrl = 3'b010;
    c = 0;
    while ((bus.me_req === 1'b1 || bus.fe_req === 1'b1) && c < 100) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.me_valid === 1'b1) begin
        k++;
        if (k < 6) bus.me_addr = 32'h300 + 32'(4 * k);
        else bus.me_req = 0;
      end
      if (bus.fe_valid === 1'b1) begin
        fe_pos = k;
        bus.fe_req = 0;
      end
      c++;
    end
    checks++;
    if (fe_pos != n_before || k != 6) begin
      errors++;
      $display("FAIL starve fe_after=%0d me_done=%0d exp %0d 6", fe_pos, k, n_before);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ack_delay = 0;
    auto_ack = 1;
    rst = 1;
    memory[32'h10] = 32'h0050_0093;
    test_reset();
    test_fetch_basic();
    repeat (2) @(negedge clk);
    test_priority();
    repeat (2) @(negedge clk);
    test_store();
    repeat (2) @(negedge clk);
    test_flush();
    repeat (2) @(negedge clk);
    test_reset_midway();
    repeat (2) @(negedge clk);
    test_starve();
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (grant_q.size() != 0 || fe_q.size() != 0 || me_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left grants=%0d fe=%0d me=%0d exp 0 0 0",
               grant_q.size(), fe_q.size(), me_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imem_dmem_arbiter
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Sequences each access over a variable-latency memory handshake and returns per-requester stall signals, which the hazard unit ORs into its enable/clear logic.
- The data port has priority because it carries the older instruction.
- A pending fetch can be discarded on a taken branch/jump.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- fe_req  in  1  fetch request; level, held until fe_valid or flush
- fe_addr  in  ADDR_W  fetch PC
- fe_rdata  out  DATA_W  fetched instruction; valid with fe_valid
- fe_valid  out  1  one-cycle response pulse
- fe_stall  out  1  fetch must hold PC and the IF/DE registers
- flush  in  1  taken branch/jump (NextPCSrc); kills the current fetch
- me_req  in  1  data request; level, held until me_valid
- me_we  in  1  1 = store, 0 = load
- me_addr  in  ADDR_W  data address (ALU result)
- me_wdata  in  DATA_W  store data
- me_ctrl  in  3  DMCtrl size/sign code, passed through
- me_rdata  out  DATA_W  load data; valid with me_valid
- me_valid  out  1  one-cycle response pulse (also pulses for stores)
- me_stall  out  1  memory stage must hold
- mem_req  out  1  request to memory; held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_ctrl  out  registered copy of the granted request
- mem_rdata  in  DATA_W  read data, sampled on mem_ack
- mem_ack  in  1  completion; may assert in the first cycle of mem_req

Behaviour:
- States: IDLE, BUSY_FE, BUSY_ME, RESP.
- Reset (sync, rst=1 at an edge):
  - state = IDLE.
  - mem_req, fe_valid, me_valid, and the discard flag = 0.
  - rdata outputs and registered mem_* buses = 0.
  - An ack arriving after reset is ignored.
  - Reset mid-transaction drops it silently.
- IDLE arbitration:
  - me_req wins over fe_req.
  - A fetch is not granted in a cycle where flush=1.
  - On grant, the request is registered into mem_*, mem_req=1 next cycle, and state moves to BUSY_ME or BUSY_FE.
- BUSY_x:
  - mem_req and the mem_* buses stay stable until mem_ack.
  - On mem_ack, mem_rdata is captured into x_rdata, mem_req=0, and state moves to RESP.
  - If the discard flag is set, the data is not delivered.
- RESP (one cycle):
  - The registered valid pulse for the owner is high, unless the fetch was discarded.
  - No arbitration this cycle, so a requester still holding req on its valid cycle is not re-granted.
  - Next state is IDLE.
- Latency: req seen at cycle t (IDLE) → mem_req at t+1 → ack at earliest t+1 → valid at t+2. Minimum is 3 cycles per access.
- Stalls (combinational):
  - fe_stall = fe_req & ~fe_valid; me_stall = me_req & ~me_valid.
  - fe_stall is also forced to 1 while BUSY_FE has discard set, so the new PC waits for the port.
- Flush:
  - In BUSY_FE: set discard; the transaction completes on the bus and no fe_valid is issued.
  - In IDLE, RESP, or BUSY_ME: no effect.
  - Discard clears on entry to IDLE.
- Simultaneous fe_req and me_req in IDLE: grant ME; fetch waits with fe_stall=1.
- A store completes like a load; me_rdata is undefined for stores, and me_valid still pulses.

Optional Feature:
- Macro: ARB_STARVE_EN.
- Defined:
  - A counter increments on each ME grant while fe_req=1, and resets on an FE grant or when fe_req=0.
  - When the counter reaches STARVE_MAX, the next IDLE arbitration grants FE even if me_req=1.
- Undefined: ME has strict priority, and no counter exists.

Decomposition:
- Package arb_pkg holds:
  - the state enum typedef (IDLE, BUSY_FE, BUSY_ME, RESP);
  - localparam DMCTRL_W=3;
  - owner typedef {OWN_FE, OWN_ME}.
- One sub-module, arb_starve_ctr (counter plus force_fe output), instantiated only under ARB_STARVE_EN.
- The FSM and datapath stay in the top module.

Test Plan:
1. fe_req=1, fe_addr=0x0000_0010, mem_ack returned 1 cycle after mem_req, mem_rdata=0x0050_0093 → mem_addr=0x10; fe_valid pulses once, 3 cycles after req, with fe_rdata=0x0050_0093; fe_stall is high for cycles 0–1.
2. fe_req and me_req (load, me_addr=0x0000_0100) both rise at cycle 0, ack is immediate → ME is served first (me_valid at cycle 2), then FE is granted at cycle 3 (fe_valid at cycle 5).
3. Store: me_we=1, me_addr=0x200, me_wdata=0xDEAD_BEEF, me_ctrl=3'b010 → mem_we=1 and the mem_* buses match, stable for 4 cycles while mem_ack is delayed 4 cycles; me_valid pulses once.
4. Fetch in flight, flush=1 in cycle 2, ack in cycle 4 → no fe_valid, fe_stall=1 through cycle 4; the new fe_addr=0x0000_0080 is granted from IDLE in cycle 6.
5. rst=1 during BUSY_ME with mem_ack arriving 1 cycle after reset deasserts → mem_req=0, no me_valid, state=IDLE.
6. With ARB_STARVE_EN, STARVE_MAX=4, me_req held high with back-to-back requests, fe_req=1 → the 5th grant goes to FE; without the macro, FE is never granted.
